// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Constants and the FSM state encoding shared by the UART receiver and the
//   UART transmitter.
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int          OVERSAMPLE = 16;     // ticks per bit period
    localparam int          DATA_BITS  = 8;
    localparam logic [3:0]  MID_TICK   = 4'd7;   // middle of the start bit
    localparam logic [3:0]  LAST_TICK  = 4'd15;  // one full bit period later
    localparam logic [2:0]  LAST_BIT   = 3'(DATA_BITS - 1);

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
//   Free-running divider producing a one-cycle tick at BAUD*OVERSAMPLE Hz.
//   Ports:
//     sysclk  in   system clock
//     reset   in   asynchronous active-low reset
//     tick    out  high for one sysclk cycle every DIV cycles
// ---------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic sysclk,
    input  logic reset,
    output logic tick
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    generate
        if (DIV < 1) begin : g_div_check
            $error("uart_baud_tick: CLK_FREQ too low for BAUD*OVERSAMPLE");
        end
    endgenerate

    logic [CW-1:0] cnt_q;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte
//   8N1 UART receiver with a one-byte holding register on a valid/ready
//   handshake. Framing errors and overruns are reported as 1-cycle pulses.
//   Ports:
//     sysclk        in   system clock
//     reset         in   asynchronous active-low reset
//     UART_RX       in   serial line, asynchronous, idle high
//     rx_ready      in   consumer takes rx_data when rx_valid && rx_ready
//     rx_data       out  received byte, stable while rx_valid
//     rx_valid      out  holding register full
//     rx_frame_err  out  pulse: stop bit sampled low, byte discarded
//     rx_overrun    out  pulse: byte completed while holding full, dropped
//     rx_busy       out  receiver FSM not idle
// ---------------------------------------------------------------------------
module uart_rx_byte #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       UART_RX,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
);

    import uart_pkg::*;

    generate
        if (OVERSAMPLE != uart_pkg::OVERSAMPLE) begin : g_os_check
            $error("uart_rx_byte: OVERSAMPLE must be 16");
        end
    endgenerate

    logic tick;

    uart_baud_tick #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .sysclk (sysclk),
        .reset  (reset),
        .tick   (tick)
    );

    // Two-flop synchroniser; resets to the idle line level so no false start.
    logic rx_meta_q, rx_s_q;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= UART_RX;
            rx_s_q    <= rx_meta_q;
        end
    end

    uart_state_e          state_q, state_d;
    logic [3:0]           s_q, s_d;
    logic [2:0]           b_q, b_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;

    // State register
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            b_q     <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            b_q     <= b_d;
            shift_q <= shift_d;
        end
    end

    // Next state: everything moves only on oversample ticks
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        b_d     = b_q;
        shift_d = shift_q;
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s_q) begin
                        state_d = ST_START;
                        s_d     = '0;
                    end
                end
                ST_START: begin
                    if (s_q == MID_TICK) begin
                        s_d = '0;
                        b_d = '0;
                        // Line back high at mid start bit: treat as a glitch.
                        state_d = rx_s_q ? ST_IDLE : ST_DATA;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (s_q == LAST_TICK) begin
                        // LSB arrives first, so shift in from the top.
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        s_d     = '0;
                        b_d     = b_q + 1'b1;
                        if (b_q == LAST_BIT) state_d = ST_STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    // Leave at mid stop bit so a back-to-back start edge is seen.
                    if (s_q == LAST_TICK) begin
                        state_d = ST_IDLE;
                        s_d     = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs
    logic stop_tick, deliver, frame_bad;

    always_comb begin
        rx_busy   = (state_q != ST_IDLE);
        stop_tick = tick && (state_q == ST_STOP) && (s_q == LAST_TICK);
        deliver   = stop_tick && rx_s_q;
        frame_bad = stop_tick && !rx_s_q;
    end

    // Holding register and status pulses
    logic [7:0] data_q;
    logic       valid_q, fe_q, ov_q;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            fe_q <= frame_bad;
            ov_q <= deliver && valid_q && !rx_ready;
            // A drain in the same cycle as a delivery frees the slot at once.
            if (deliver && (!valid_q || rx_ready)) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = fe_q;
    assign rx_overrun   = ov_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
module tb_uart_rx_byte;

    localparam int CLK_FREQ = 3_200_000;
    localparam int BAUD     = 100_000;
    localparam int BIT_CLKS = 32;

    logic       sysclk   = 1'b0;
    logic       reset    = 1'b0;
    logic       UART_RX  = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err, rx_overrun, rx_busy;

    uart_rx_byte #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (16)
    ) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .UART_RX      (UART_RX),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_busy      (rx_busy)
    );

    always #5 sysclk = ~sysclk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    // Monitor: samples on the falling edge, records each newly presented byte
    // and counts status activity.
    int   cyc = 0, evt_cyc = 0;
    int   n_vld = 0, n_fall = 0, n_fe = 0, n_ov = 0, n_busy = 0;
    logic pv = 1'b0, pr = 1'b0;

    always @(negedge sysclk) begin
        cyc++;
        if (rx_valid && (!pv || pr)) begin
            got_q.push_back(rx_data);
            evt_cyc = cyc;
        end
        if (pv && !rx_valid) n_fall++;
        if (rx_valid)     n_vld++;
        if (rx_frame_err) n_fe++;
        if (rx_overrun)   n_ov++;
        if (rx_busy)      n_busy++;
        pv = rx_valid;
        pr = rx_ready;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        UART_RX = 1'b1;
        clk_n(n);
    endtask

    // One full frame; rdy_at >= 0 raises rx_ready for exactly the edge after
    // iteration rdy_at.
    task automatic send(input logic [7:0] d, input logic stop, input int rdy_at);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        for (int i = 0; i < 10 * BIT_CLKS; i++) begin
            UART_RX = fr[i / BIT_CLKS];
            if (rdy_at >= 0) begin
                if (i == rdy_at)          rx_ready = 1'b1;
                else if (i == rdy_at + 1) rx_ready = 1'b0;
            end
            @(posedge sysclk);
            #1;
        end
        UART_RX = 1'b1;
    endtask

    task automatic check_sb(input string tag);
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() == 0) chk({tag, "_missing"}, got_q.size(), 1);
            else                   chk(tag, int'(got_q.pop_front()), int'(e));
        end
        chk({tag, "_extra"}, got_q.size(), 0);
    endtask

    int v0, f0, o0, b0, fl0, t0, d;

    initial begin
        clk_n(5);
        chk("rst_valid", int'(rx_valid), 0);
        chk("rst_data",  int'(rx_data), 'h00);
        chk("rst_fe",    int'(rx_frame_err), 0);
        chk("rst_ov",    int'(rx_overrun), 0);
        chk("rst_busy",  int'(rx_busy), 0);
        reset = 1'b1;
        clk_n(10);

        // 1: single byte, consumer always ready
        rx_ready = 1'b1;
        v0 = n_vld; f0 = n_fe; o0 = n_ov;
        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1, -1);
        idle(40);
        chk("t1_vld_width", n_vld - v0, 1);
        chk("t1_fe", n_fe - f0, 0);
        chk("t1_ov", n_ov - o0, 0);
        check_sb("t1_data");

        // 2: back-to-back with consumer stalled -> overrun on the second
        rx_ready = 1'b0;
        f0 = n_fe; o0 = n_ov;
        exp_q.push_back(8'h3C);
        send(8'h3C, 1'b1, -1);
        send(8'hC3, 1'b1, -1);
        idle(40);
        chk("t2_valid", int'(rx_valid), 1);
        chk("t2_hold",  int'(rx_data), 'h3C);
        chk("t2_ov",    n_ov - o0, 1);
        chk("t2_fe",    n_fe - f0, 0);
        check_sb("t2_data");
        rx_ready = 1'b1;
        clk_n(1);
        chk("t2_drain_valid", int'(rx_valid), 0);
        chk("t2_drain_data",  int'(rx_data), 'h3C);

        // 3: bad stop bit, then a clean byte
        v0 = n_vld; f0 = n_fe; o0 = n_ov;
        send(8'h55, 1'b0, -1);
        idle(64);
        chk("t3_fe",  n_fe - f0, 1);
        chk("t3_vld", n_vld - v0, 0);
        exp_q.push_back(8'h0F);
        send(8'h0F, 1'b1, -1);
        idle(40);
        check_sb("t3_data");
        chk("t3_fe_once", n_fe - f0, 1);
        chk("t3_ov", n_ov - o0, 0);

        // 4: short low glitch
        v0 = n_vld; f0 = n_fe; o0 = n_ov; b0 = n_busy;
        UART_RX = 1'b0;
        clk_n(4);
        idle(60);
        chk("t4_busy_seen", int'(n_busy - b0 > 0), 1);
        chk("t4_busy_end",  int'(rx_busy), 0);
        chk("t4_vld", n_vld - v0, 0);
        chk("t4_fe",  n_fe - f0, 0);
        chk("t4_ov",  n_ov - o0, 0);
        check_sb("t4_none");

        // 5: reset in the middle of data bit 4 of 8'hFF
        UART_RX = 1'b0;
        clk_n(BIT_CLKS);
        UART_RX = 1'b1;
        clk_n(BIT_CLKS * 4 + BIT_CLKS / 2);
        reset = 1'b0;
        clk_n(2);
        chk("t5_rst_valid", int'(rx_valid), 0);
        chk("t5_rst_data",  int'(rx_data), 'h00);
        chk("t5_rst_fe",    int'(rx_frame_err), 0);
        chk("t5_rst_ov",    int'(rx_overrun), 0);
        chk("t5_rst_busy",  int'(rx_busy), 0);
        clk_n(10);
        reset = 1'b1;
        idle(20);
        f0 = n_fe; o0 = n_ov;
        exp_q.push_back(8'h81);
        send(8'h81, 1'b1, -1);
        idle(40);
        check_sb("t5_data");
        chk("t5_fe", n_fe - f0, 0);
        chk("t5_ov", n_ov - o0, 0);

        // 6: drain in the exact delivery cycle of the next byte
        rx_ready = 1'b0;
        o0 = n_ov;
        exp_q.push_back(8'h11);
        t0 = cyc;
        send(8'h11, 1'b1, -1);
        d = evt_cyc - t0 - 1;           // edge index of delivery within a frame
        idle(64);                       // even offset keeps tick phase aligned
        fl0 = n_fall;
        exp_q.push_back(8'h22);
        send(8'h22, 1'b1, d - 1);
        idle(10);
        chk("t6_valid", int'(rx_valid), 1);
        chk("t6_data",  int'(rx_data), 'h22);
        chk("t6_ov",    n_ov - o0, 0);
        chk("t6_no_gap", n_fall - fl0, 0);
        check_sb("t6_data");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
